sram_bus_arbiter: RTL and testbench

//  Shares one sram-like memory port between the IF-stage instruction fetch and the MEM-stage data access.

---
 rtl/sram_bus_arbiter_pkg.sv | 24 ++
 rtl/sram_bus_arbiter_if.sv | 66 ++++++
 rtl/sram_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter_pkg
// Shared types for the instruction/data SRAM-port arbiter.
//   ARB_ADDR_W / ARB_DATA_W : default address and data widths
//   arb_state_e             : arbiter FSM state codes (IDLE -> ADDR -> DATA)
//   arb_owner_e             : which requester currently owns the memory port
// ---------------------------------------------------------------------------
package sram_bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter_if
// Bundles every handshake/bus signal around the arbiter: the IF-stage fetch
// port, the MEM-stage data port, the shared downstream SRAM-like port and the
// busy hint.
//   modport slave  : the arbiter's view (requests and memory replies in,
//                    responses and downstream request out)
//   modport master : the surrounding pipeline + memory view (the mirror)
// ---------------------------------------------------------------------------
interface sram_bus_arbiter_if
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);

    // Instruction fetch port
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_data_ok;
    logic                  inst_flush;

    // Data access port
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_data_ok;

    // Shared downstream memory port
    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    // Pipeline stall hint
    logic                  busy;

    modport slave (
        input  inst_req, inst_addr, inst_flush,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, inst_data_ok,
        output data_rdata, data_data_ok,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output inst_req, inst_addr, inst_flush,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, inst_data_ok,
        input  data_rdata, data_data_ok,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like memory port between instruction fetch and data access.
// One transaction at a time; data wins when both ask in the same idle cycle.
// Runs the addr_ok/data_ok handshake and steers read data back to the owner.
// A flushed fetch still completes its bus handshake but its reply is dropped.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sram_bus_arbiter_if.slave (fetch port, data port, memory port, busy)
// ---------------------------------------------------------------------------
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    sram_bus_arbiter_if.slave bus
);

    arb_state_e            state_q;
    arb_owner_e            owner_q;
    logic                  discard_q;
    logic                  memReq_q;
    logic                  memWr_q;
    logic [DATA_W/8-1:0]   memWstrb_q;
    logic [ADDR_W-1:0]     memAddr_q;
    logic [DATA_W-1:0]     memWdata_q;

    logic                  respValid;
    logic                  instFlushHit;

    // A flush only matters while the fetch owns the port; a flush during a
    // data transaction leaves that transaction untouched.
    assign instFlushHit = bus.inst_flush && (owner_q == OWNER_INST);

    // Arbiter FSM. The request fields are captured at grant time so the
    // downstream request stays stable under addr_ok backpressure even if the
    // requester changes its inputs. A fetch grant drives a read, so write
    // enable, strobes and write data are forced to zero. Grants are only
    // made from IDLE, so a reply in DATA never overlaps a new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_INST;
            discard_q  <= 1'b0;
            memReq_q   <= 1'b0;
            memWr_q    <= 1'b0;
            memWstrb_q <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    discard_q <= 1'b0;
                    if (bus.data_req) begin
                        owner_q    <= OWNER_DATA;
                        memReq_q   <= 1'b1;
                        memWr_q    <= bus.data_wr;
                        memWstrb_q <= bus.data_wstrb;
                        memAddr_q  <= bus.data_addr;
                        memWdata_q <= bus.data_wdata;
                        state_q    <= ARB_ADDR;
                    end else if (bus.inst_req && !bus.inst_flush) begin
                        owner_q    <= OWNER_INST;
                        memReq_q   <= 1'b1;
                        memWr_q    <= 1'b0;
                        memWstrb_q <= '0;
                        memAddr_q  <= bus.inst_addr;
                        memWdata_q <= '0;
                        state_q    <= ARB_ADDR;
                    end
                end

                ARB_ADDR: begin
                    // The request is already visible downstream, so a flush
                    // here cannot withdraw it; mark the reply for discard.
                    if (instFlushHit) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.mem_addr_ok) begin
                        memReq_q <= 1'b0;
                        state_q  <= ARB_DATA;
                    end
                end

                ARB_DATA: begin
                    if (instFlushHit) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.mem_data_ok) begin
                        discard_q <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end
                end

                default: begin
                    memReq_q <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

    // Return path: the reply is forwarded in the same cycle mem_data_ok
    // arrives. A fetch reply is suppressed if it was flushed earlier or is
    // being flushed in the very cycle it returns. Read data is gated by the
    // completion pulse so both rdata ports idle at zero.
    always_comb begin
        respValid        = (state_q == ARB_DATA) && bus.mem_data_ok;
        bus.inst_data_ok = respValid && (owner_q == OWNER_INST) &&
                           !discard_q && !bus.inst_flush;
        bus.data_data_ok = respValid && (owner_q == OWNER_DATA);
        bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : '0;
        bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : '0;
    end

    // Downstream request fields come straight from the capture registers.
    always_comb begin
        bus.mem_req   = memReq_q;
        bus.mem_wr    = memWr_q;
        bus.mem_wstrb = memWstrb_q;
        bus.mem_addr  = memAddr_q;
        bus.mem_wdata = memWdata_q;
        bus.busy      = (state_q != ARB_IDLE);
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed bench for sram_bus_arbiter. The bench plays both the pipeline and
// the memory. Each request whose completion is expected pushes an entry
// (owner, read data) into a scoreboard; a monitor pops it when a *_data_ok
// pulse appears. Inputs change on the falling edge; outputs are sampled on
// the falling edge (registered) or shortly after it (combinational replies).
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    typedef struct {
        logic        isInst;
        logic [31:0] rdata;
    } sbEntry_t;

    logic clk;
    logic rst;
    int   totalChecks;
    int   badChecks;
    int   waitCycles;
    sbEntry_t sbQueue[$];

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalChecks++;
        assert (obs === exp) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive both requester ports at once.
    task automatic applyStimulus(input logic instReq, input logic [31:0] instAddr,
                                 input logic dataReq, input logic dataWr,
                                 input logic [3:0] dataWstrb, input logic [31:0] dataAddr,
                                 input logic [31:0] dataWdata);
        bus.inst_req   = instReq;
        bus.inst_addr  = instAddr;
        bus.data_req   = dataReq;
        bus.data_wr    = dataWr;
        bus.data_wstrb = dataWstrb;
        bus.data_addr  = dataAddr;
        bus.data_wdata = dataWdata;
    endtask

    task automatic pushExpected(input logic isInst, input logic [31:0] rdata);
        sbEntry_t e;
        e.isInst = isInst;
        e.rdata  = rdata;
        sbQueue.push_back(e);
    endtask

    // Wait (bounded) for mem_req; returns the number of falling edges taken.
    task automatic waitReq(input string tag, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
        end
        checkOutput({tag, "_req_seen"}, 128'(found), 128'(1'b1));
    endtask

    // Memory model: hold addr_ok low for addrWait cycles while checking the
    // request stays stable, accept it, then reply dataWait cycles later.
    task automatic memRespond(input string tag, input int addrWait, input int dataWait,
                              input logic [31:0] rdata, input logic [31:0] expAddr,
                              input logic expWr, input logic [3:0] expWstrb,
                              input logic [31:0] expWdata);
        checkOutput({tag, "_req_fields"},
                    128'({bus.mem_req, bus.busy, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}),
                    128'({1'b1, 1'b1, expWr, expWstrb, expAddr, expWdata}));
        for (int i = 0; i < addrWait; i++) begin
            @(negedge clk);
            checkOutput({tag, "_req_stable"},
                        128'({bus.mem_req, bus.busy, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}),
                        128'({1'b1, 1'b1, expWr, expWstrb, expAddr, expWdata}));
        end
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        checkOutput({tag, "_data_phase"}, 128'({bus.mem_req, bus.busy}), 128'(2'b01));
        for (int i = 0; i < dataWait; i++) begin
            @(negedge clk);
        end
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = rdata;
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest entry.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && (bus.inst_data_ok || bus.data_data_ok)) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_data_ok",
                                128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b00));
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("response",
                                128'({bus.inst_data_ok, bus.data_data_ok,
                                      (e.isInst ? bus.inst_rdata : bus.data_rdata)}),
                                128'({e.isInst, ~e.isInst, e.rdata}));
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        totalChecks     = 0;
        badChecks       = 0;
        rst             = 1'b1;
        bus.inst_flush  = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset_outputs",
                    128'({bus.mem_req, bus.busy, bus.mem_wr, bus.mem_wstrb, bus.mem_addr,
                          bus.mem_wdata, bus.inst_data_ok, bus.data_data_ok}),
                    128'(0));

        $display("[TB] load");
        pushExpected(1'b0, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
        waitReq("load", waitCycles);
        checkOutput("load_latency", 128'(waitCycles), 128'(1));
        memRespond("load", 1, 0, 32'h1234_5678, 32'h8000_0010, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("load_idle", 128'(bus.busy), 128'(0));

        $display("[TB] store");
        pushExpected(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h8000_0020, 32'hABAB_ABAB);
        waitReq("store", waitCycles);
        memRespond("store", 2, 1, 32'h0, 32'h8000_0020, 1'b1, 4'b0100, 32'hABAB_ABAB);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        $display("[TB] conflict");
        pushExpected(1'b0, 32'h1111_2222);
        pushExpected(1'b1, 32'h3333_4444);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h8000_0030, 32'h0);
        waitReq("conflict_data", waitCycles);
        memRespond("conflict_data", 0, 0, 32'h1111_2222, 32'h8000_0030, 1'b0, 4'h0, 32'h0);
        bus.data_req = 1'b0;
        waitReq("conflict_inst", waitCycles);
        memRespond("conflict_inst", 0, 2, 32'h3333_4444, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
        bus.inst_req = 1'b0;
        checkOutput("conflict_drained", 128'(sbQueue.size()), 128'(0));

        $display("[TB] flush in data phase");
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitReq("flush", waitCycles);
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        bus.inst_flush  = 1'b1;
        bus.inst_req    = 1'b0;
        @(negedge clk);
        bus.inst_flush  = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hDEAD_BEEF;
        #2;
        checkOutput("flush_no_inst_ok", 128'(bus.inst_data_ok), 128'(0));
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        checkOutput("flush_idle", 128'(bus.busy), 128'(0));

        $display("[TB] fetch after flush, backpressure");
        pushExpected(1'b1, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b1, 4'hF, 32'h8000_0050, 32'h5555_5555);
        waitReq("refetch", waitCycles);
        memRespond("refetch", 5, 0, 32'hCAFE_F00D, 32'h0000_1004, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        $display("[TB] reset in data phase");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0040, 32'h0);
        waitReq("rstmid", waitCycles);
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        rst = 1'b1;
        bus.data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h0000_0077;
        #2;
        checkOutput("rstmid_no_ok", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b00));
        checkOutput("rstmid_outputs",
                    128'({bus.mem_req, bus.busy, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}),
                    128'(0));
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        @(negedge clk);
        checkOutput("sb_drained", 128'(sbQueue.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
